// File: rtl/wb_bram_pkg.sv
// Shared types and defaults for the Wishbone-to-BRAM bridge.
package wb_bram_pkg;
    localparam int SEL_W  = 4;
    localparam int DATA_W = 32;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h3800_0000;
    localparam int          DEF_DEC_BITS    = 12;
    localparam int          DEF_ADDR_WIDTH  = 10;
    localparam int          DEF_WAIT_STATES = 10;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] dat;
    } wb_req_t;

    // $clog2(1) is 0, so a zero-wait build still needs a one-bit counter
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction
endpackage

// File: rtl/bram_bytewe.sv
// Single-port block RAM with per-byte write enables, registered read-first output.
module bram_bytewe
    import wb_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [SEL_W-1:0]      we,
    input  logic [ADDR_WIDTH-1:0] a,
    input  logic [DATA_W-1:0]     di,
    output logic [DATA_W-1:0]     dout
);
    logic [SEL_W-1:0][7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[a];
            for (int i = 0; i < SEL_W; i++)
                if (we[i]) mem[a][i] <= di[8*i +: 8];
        end
    end
endmodule

// File: rtl/wb_bram_bridge.sv
// Wishbone-classic slave in front of a byte-writable BRAM, with a fixed
// wait-state count, abort on strobe drop and a busy flag.
module wb_bram_bridge
    import wb_bram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEC_BITS    = DEF_DEC_BITS,
    parameter int          ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int          WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [SEL_W-1:0]  wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic              busy_o
);
    localparam int CNT_W = cnt_width(WAIT_STATES);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] idx;
    wb_req_t               req;
    logic                  ack_q, busy_q;
    logic [DATA_W-1:0]     ram_dout;

    logic stb_act, hit, ram_en;
    logic [SEL_W-1:0] ram_we;
    logic unused_adr;

    assign stb_act    = wbs_cyc_i & wbs_stb_i;
    assign hit        = stb_act && (wbs_adr_i[31:32-DEC_BITS] == BASE_ADDR[31:32-DEC_BITS]);
    assign unused_adr = ^wbs_adr_i;

    // RAM is touched only on the last wait cycle, so an aborted or reset
    // transfer never reaches memory.
    assign ram_en = (state == WAIT) && stb_act && (cnt == '0);
    assign ram_we = {SEL_W{ram_en & req.we}} & req.sel;

    bram_bytewe #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk  (wb_clk_i),
        .en   (ram_en),
        .we   (ram_we),
        .a    (idx),
        .di   (req.dat),
        .dout (ram_dout)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            req    <= '0;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (hit) begin
                        idx    <= wbs_adr_i[ADDR_WIDTH+1:2];
                        req    <= '{we: wbs_we_i, sel: wbs_sel_i, dat: wbs_dat_i};
                        cnt    <= CNT_W'(WAIT_STATES);
                        state  <= WAIT;
                        busy_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!stb_act) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign busy_o    = busy_q;
    assign wbs_dat_o = (ack_q && !req.we) ? ram_dout : '0;
endmodule

// File: tb/tb_wb_bram_bridge.sv
// Directed bench: one bridge with 10 wait states, one with zero for back-to-back.
module tb_wb_bram_bridge;
    localparam int WS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cyc = 0, stb = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, dat = 0;
    logic        ack, busy;
    logic [31:0] dato;

    logic        cyc0 = 0, stb0 = 0, we0 = 0;
    logic [3:0]  sel0 = 0;
    logic [31:0] adr0 = 0, dat0 = 0;
    logic        ack0, busy0;
    logic [31:0] dato0;

    int n_vec = 0;
    int n_err = 0;

    wb_bram_bridge #(.WAIT_STATES(WS)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack), .wbs_dat_o(dato), .busy_o(busy)
    );

    wb_bram_bridge #(.WAIT_STATES(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc0), .wbs_stb_i(stb0), .wbs_we_i(we0), .wbs_sel_i(sel0),
        .wbs_adr_i(adr0), .wbs_dat_i(dat0),
        .wbs_ack_o(ack0), .wbs_dat_o(dato0), .busy_o(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full transfer on the 10-wait-state bridge; inputs are scrambled after
    // accept to show the latched copy is what gets used.
    task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
        int lat = -1;
        logic [31:0] got = '1;
        logic b0 = 1'b1, b1 = 1'b0;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 0) b0 = busy;
            if (k == 1) b1 = busy;
            if (k == 3) begin adr = ~a; dat = ~d; sel = ~s; we = ~w; end
            if (ack) begin lat = k; got = dato; end
        end
        chk({tag, " latency"}, lat, 32'(WS + 2));
        chk({tag, " data"}, got, exp);
        chk({tag, " busy c0/c1"}, {30'd0, b0, b1}, 32'd1);
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    initial begin
        logic seen_ack, seen_busy;
        int i;
        logic [31:0] ops_d [4];
        logic        ops_w [4];
        ops_w = '{1'b1, 1'b0, 1'b1, 1'b0};
        ops_d = '{32'hA5A5_0001, 32'hA5A5_0001, 32'h5A5A_0002, 32'h5A5A_0002};

        repeat (2) @(negedge clk);
        chk("reset ack", {31'd0, ack}, 32'd0);
        chk("reset dat", dato, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset dut0 ack/busy", {30'd0, ack0, busy0}, 32'd0);
        rst = 0;

        xfer("wr deadbeef", 1, 32'h3800_0004, 32'hDEAD_BEEF, 4'hF, 32'h0);
        xfer("rd deadbeef", 0, 32'h3800_0004, 32'h0, 4'hF, 32'hDEAD_BEEF);

        xfer("wr preload w1", 1, 32'h3800_0004, 32'h1122_3344, 4'hF, 32'h0);
        xfer("wr lane1", 1, 32'h3800_0004, 32'h0000_AB00, 4'b0010, 32'h0);
        xfer("rd lane1", 0, 32'h3800_0004, 32'h0, 4'hF, 32'h1122_AB44);
        xfer("rd alias", 0, 32'h3800_1004, 32'h0, 4'hF, 32'h1122_AB44);

        // abort: strobe dropped in c5 of a write to word 2
        xfer("wr clear w2", 1, 32'h3800_0008, 32'h0, 4'hF, 32'h0);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h3800_0008; dat = 32'hCAFE_F00D; sel = 4'hF;
        repeat (5) @(posedge clk);
        #1; cyc = 0; stb = 0;
        @(negedge clk); chk("abort busy c5", {31'd0, busy}, 32'd1);
        @(negedge clk); chk("abort busy c6", {31'd0, busy}, 32'd0);
        seen_ack = ack;
        repeat (15) begin @(negedge clk); seen_ack |= ack; end
        chk("abort no ack", {31'd0, seen_ack}, 32'd0);
        xfer("rd w2 after abort", 0, 32'h3800_0008, 32'h0, 4'hF, 32'h0);

        // decode miss
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 32'h3000_0000; sel = 4'hF;
        seen_ack = 0; seen_busy = 0;
        repeat (20) begin @(negedge clk); seen_ack |= ack; seen_busy |= busy; end
        chk("miss ack", {31'd0, seen_ack}, 32'd0);
        chk("miss busy", {31'd0, seen_busy}, 32'd0);
        @(posedge clk); #1; cyc = 0; stb = 0;

        // reset in the middle of a write to word 3
        xfer("wr w3", 1, 32'h3800_000C, 32'h3333_3333, 4'hF, 32'h0);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = 32'h3800_000C; dat = 32'h9999_9999; sel = 4'hF;
        repeat (4) @(negedge clk);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        #2 rst = 1;
        #1;
        chk("async reset ack/busy", {30'd0, ack, busy}, 32'd0);
        chk("async reset dat", dato, 32'd0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk); rst = 0;
        xfer("rd w3 after reset", 0, 32'h3800_000C, 32'h0, 4'hF, 32'h3333_3333);

        // zero wait states, continuous strobe, alternating write/read of word 5
        i = 0;
        @(posedge clk); #1;
        cyc0 = 1; stb0 = 1; sel0 = 4'hF; adr0 = 32'h3800_0014;
        we0 = ops_w[0]; dat0 = ops_d[0];
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (ack0) begin
                chk($sformatf("b2b op%0d ack cycle", i), k, 32'(3 * i + 2));
                chk($sformatf("b2b op%0d data", i), dato0, ops_w[i] ? 32'h0 : ops_d[i]);
                i++;
                @(posedge clk); #1;
                if (i < 4) begin
                    we0 = ops_w[i]; dat0 = ops_w[i] ? ops_d[i] : 32'h0;
                end else begin
                    cyc0 = 0; stb0 = 0;
                end
            end
        end
        chk("b2b ack count", i, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_bram_bridge.md
Name: wb_bram_bridge

Overview:
- Parametrised Wishbone-classic slave fronting an internal byte-writable single-port block RAM in the user project area.
- Successor to the fixed-delay BRAM front end. Adds a configurable base-address window and depth, an exact and configurable wait-state count, and registered read data.
- Adds clean abort when the master drops the strobe (no ack, no write), and a busy status output.

Parameters:
- BASE_ADDR, 32'h3800_0000, base of decode window.
- DEC_BITS, 12, number of upper address bits compared against BASE_ADDR.
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 10, extra cycles inserted before the RAM access; legal range 0..255.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- busy_o  out  1  transaction in flight (state != IDLE).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Clock port is wb_clk_i, reset port is wb_rst_i.
- Reset values: state=IDLE, wbs_ack_o=0, wbs_dat_o=0, busy_o=0, wait counter=0, latched adr/dat/sel/we=0. RAM contents are not reset.
- Address decode: hit = cyc & stb & (adr[31:32-DEC_BITS] == BASE_ADDR[31:32-DEC_BITS]).
  - Word index = adr[ADDR_WIDTH+1:2].
  - Bits between the index and the decode field are ignored, so the window aliases.
  - adr[1:0] is ignored.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On hit: latch adr index, dat, sel and we; load counter = WAIT_STATES; go to WAIT.
  - No hit: stay in IDLE; no RAM enable.
- WAIT:
  - If !(cyc & stb): abort to IDLE. No ack, no RAM write, counter cleared.
  - Else if counter == 0: issue RAM access with EN=1 and WE = sel & {4{we}} using the latched values; go to ACK.
  - Else decrement the counter.
- ACK:
  - wbs_ack_o = 1 for exactly one cycle.
  - Read: wbs_dat_o = RAM registered output of the latched word.
  - Write: wbs_dat_o = 0.
  - Next state is always IDLE.
- wbs_dat_o = 0 whenever ack is 0.
- Latency: request first seen in cycle c0 gives ack high in cycle c0 + WAIT_STATES + 2, independent of we.
  - The earliest next accept is the cycle after ack, so back-to-back throughput is one transfer per WAIT_STATES+3 cycles.
- Write commit: the RAM write takes effect on the edge entering ACK, so an aborted transfer never modifies memory.
  - Partial writes modify only the lanes selected by sel; other bytes are retained.
- Input stability: changes to adr/dat/sel/we after accept are ignored; the latched values are used.
- Reset mid-transfer: outputs return to reset values asynchronously and the pending write is dropped.
  - The first accept is possible in the first cycle after deassertion.
- busy_o = 1 in WAIT and ACK.
- Counter width = $clog2(WAIT_STATES+1), minimum 1 bit.

Decomposition:
- Package wb_bram_pkg:
  - FSM state enum (IDLE/WAIT/ACK, 2 bits).
  - Default BASE_ADDR, DEC_BITS and WAIT_STATES constants.
  - SEL_W=4 and DATA_W=32.
- One sub-module, bram_bytewe:
  - 2**ADDR_WIDTH x 32, single port (EN, WE[3:0], A, Di, Do).
  - Registered read, read-first on a write cycle.

Test Plan:
- Write then read, WAIT_STATES=10: write 0xDEADBEEF to 0x3800_0004 with sel=F, request at c0 -> ack only in c12. Then read 0x3800_0004 -> ack in c12 with dat_o=0xDEADBEEF; busy_o high c1..c12.
- Byte lanes: preload word 1 = 0x1122_3344, write 0x0000_AB00 with sel=4'b0010 -> readback 0x1122_AB44.
- Abort: start a write of 0xCAFEF00D to word 2 (old 0x0), drop stb at c5 -> no ack, busy_o low at c6, readback of word 2 = 0x0000_0000.
- Decode miss and alias:
  - Access to 0x3000_0000 for 20 cycles -> ack never asserted, busy_o stays 0.
  - With ADDR_WIDTH=10, read 0x3800_1004 -> returns the word-1 contents.
- Reset mid-operation: assert wb_rst_i asynchronously during WAIT of a write to word 3 -> ack/busy_o 0 immediately, word 3 unchanged. A new read issued the cycle after deassertion acks normally.
- WAIT_STATES=0 back-to-back: continuous stb with alternating write/read of word 5 -> ack in c2, c5, c8..., read returns the value written just before.
